// File: rtl/flash_sr_check_pkg.sv
// Shared flash constants (opcodes, locked status values) and the status-check FSM encoding.
package flash_sr_check_pkg;

    localparam logic [7:0] FLASH_CMD_RDSR1   = 8'h05;
    localparam logic [7:0] FLASH_CMD_RDSR2   = 8'h35;
    localparam logic [7:0] FLASH_SR1_LOCKED  = 8'h28;
    localparam logic [7:0] FLASH_SR2_LOCKED  = 8'h03;

    // Counting down from 6 through 0 and then to 15 gives 8 bits; bit 3 set marks the last one.
    localparam logic [3:0] SR_BIT_RELOAD = 4'd6;

    typedef enum logic [2:0] {
        IDLE,
        START,
        CMD_LO,
        CMD_HI,
        RD_LO,
        RD_HI,
        PAUSE,
        DONE
    } sr_state_t;

    function automatic logic masked_eq(input logic [7:0] val, input logic [7:0] exp,
                                       input logic [7:0] mask);
        return ((val ^ exp) & mask) == 8'h00;
    endfunction

endpackage

// File: rtl/flash_sr_check.sv
// Reads flash SR1 then SR2 over SPI mode 0 and compares them against the expected locked values.
module flash_sr_check
    import flash_sr_check_pkg::*;
#(
    parameter logic [7:0] CMD_SR1   = FLASH_CMD_RDSR1,
    parameter logic [7:0] CMD_SR2   = FLASH_CMD_RDSR2,
    parameter logic [7:0] EXP_SR1   = FLASH_SR1_LOCKED,
    parameter logic [7:0] EXP_SR2   = FLASH_SR2_LOCKED,
    parameter logic [7:0] MASK_SR1  = 8'hFF,
    parameter logic [7:0] MASK_SR2  = 8'hFF,
    parameter int         PAUSE_LEN = 8
) (
    input  logic       clk,
    input  logic       rst,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       spi_clk,
    output logic       spi_cs_n,
    input  logic       go,
    output logic       rdy,
    output logic       done,
    output logic       match,
    output logic [7:0] sr1,
    output logic [7:0] sr2
);

    sr_state_t  state;
    logic       reg_sel;
    logic       sample_en;
    logic [3:0] bit_cnt;
    logic [3:0] pause_cnt;
    logic [7:0] cmd;
    logic [2:0] bit_sel;

    assign cmd     = reg_sel ? CMD_SR2 : CMD_SR1;
    assign bit_sel = bit_cnt[2:0] + 3'd1;
    assign rdy     = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            reg_sel   <= 1'b0;
            sample_en <= 1'b0;
            bit_cnt   <= SR_BIT_RELOAD;
            pause_cnt <= 4'd0;
            spi_cs_n  <= 1'b1;
            spi_clk   <= 1'b0;
            spi_mosi  <= 1'b0;
            done      <= 1'b0;
            match     <= 1'b0;
            sr1       <= 8'h00;
            sr2       <= 8'h00;
        end else begin
            done      <= 1'b0;
            sample_en <= (state == RD_HI);

            // Pins follow the state one cycle late, so the sample lands while spi_clk is high.
            if (sample_en) begin
                if (reg_sel) sr2 <= {sr2[6:0], spi_miso};
                else         sr1 <= {sr1[6:0], spi_miso};
            end

            case (state)
                START, CMD_LO: begin
                    spi_cs_n <= 1'b0;
                    spi_clk  <= 1'b0;
                    spi_mosi <= (state == CMD_LO) ? cmd[bit_sel] : 1'b0;
                end
                CMD_HI: begin
                    spi_cs_n <= 1'b0;
                    spi_clk  <= 1'b1;
                    spi_mosi <= cmd[bit_sel];
                end
                RD_LO, RD_HI: begin
                    spi_cs_n <= 1'b0;
                    spi_clk  <= (state == RD_HI);
                    spi_mosi <= 1'b0;
                end
                default: begin
                    spi_cs_n <= 1'b1;
                    spi_clk  <= 1'b0;
                    spi_mosi <= 1'b0;
                end
            endcase

            case (state)
                IDLE: begin
                    if (go) begin
                        state   <= START;
                        reg_sel <= 1'b0;
                        match   <= 1'b0;
                        sr1     <= 8'h00;
                        sr2     <= 8'h00;
                    end
                end
                START: begin
                    bit_cnt <= SR_BIT_RELOAD;
                    state   <= CMD_LO;
                end
                CMD_LO: state <= CMD_HI;
                CMD_HI: begin
                    if (bit_cnt[3]) begin
                        bit_cnt <= SR_BIT_RELOAD;
                        state   <= RD_LO;
                    end else begin
                        bit_cnt <= bit_cnt - 4'd1;
                        state   <= CMD_LO;
                    end
                end
                RD_LO: state <= RD_HI;
                RD_HI: begin
                    if (bit_cnt[3]) begin
                        bit_cnt   <= SR_BIT_RELOAD;
                        pause_cnt <= 4'(PAUSE_LEN - 1);
                        state     <= PAUSE;
                    end else begin
                        bit_cnt <= bit_cnt - 4'd1;
                        state   <= RD_LO;
                    end
                end
                PAUSE: begin
                    if (pause_cnt != 4'd0) begin
                        pause_cnt <= pause_cnt - 4'd1;
                    end else if (!reg_sel) begin
                        reg_sel <= 1'b1;
                        state   <= START;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                        match <= masked_eq(sr1, EXP_SR1, MASK_SR1) &&
                                 masked_eq(sr2, EXP_SR2, MASK_SR2);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_sr_check.sv
// Directed bench for flash_sr_check with a behavioural SPI flash and a pin-level protocol monitor.
module tb_flash_sr_check;

    logic       clk = 1'b0;
    logic       rst, go, spi_miso;
    logic       spi_mosi, spi_clk, spi_cs_n, rdy, done, match;
    logic [7:0] sr1, sr2;
    logic       m_mosi, m_clk, m_cs_n, m_rdy, m_done, m_match;
    logic [7:0] m_sr1, m_sr2;

    int checks = 0;
    int errors = 0;

    flash_sr_check dut (
        .clk(clk), .rst(rst), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_clk(spi_clk),
        .spi_cs_n(spi_cs_n), .go(go), .rdy(rdy), .done(done), .match(match), .sr1(sr1), .sr2(sr2)
    );

    flash_sr_check #(.MASK_SR1(8'h3C)) dut_m (
        .clk(clk), .rst(rst), .spi_mosi(m_mosi), .spi_miso(spi_miso), .spi_clk(m_clk),
        .spi_cs_n(m_cs_n), .go(go), .rdy(m_rdy), .done(m_done), .match(m_match), .sr1(m_sr1),
        .sr2(m_sr2)
    );

    always #5 clk = ~clk;

    // Flash model: opcode in on rising spi_clk, status byte out on falling spi_clk.
    logic [7:0] model_sr1, model_sr2, op;
    int         edges = 0;
    int         proto_err = 0;
    int         win_cnt = 0;
    int         win_len[$];
    int         win_edges[$];
    logic [7:0] win_op[$];

    function automatic logic [7:0] model_data(input logic [7:0] opc);
        if (opc == 8'h05) return model_sr1;
        if (opc == 8'h35) return model_sr2;
        return 8'h00;
    endfunction

    always @(negedge spi_cs_n) begin
        edges    = 0;
        op       = 8'h00;
        spi_miso = 1'b0;
    end

    always @(posedge spi_cs_n) begin
        win_edges.push_back(edges);
        win_op.push_back(op);
    end

    always @(posedge spi_clk) begin
        if (edges < 8) op = {op[6:0], spi_mosi};
        edges = edges + 1;
    end

    always @(negedge spi_clk) begin
        #1;
        if (edges >= 8 && edges < 16) begin
            logic [7:0] d;
            d = model_data(op);
            spi_miso = d[15 - edges];
        end
    end

    logic prev_sclk = 1'b0;
    logic prev_mosi = 1'b0;
    always @(negedge clk) begin
        if (spi_clk && spi_cs_n) proto_err = proto_err + 1;
        if (spi_clk && prev_sclk && spi_mosi !== prev_mosi) proto_err = proto_err + 1;
        prev_sclk = spi_clk;
        prev_mosi = spi_mosi;
        if (!spi_cs_n) win_cnt = win_cnt + 1;
        else if (win_cnt > 0) begin
            win_len.push_back(win_cnt);
            win_cnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic logic [7:0] qop(input int i);
        return (i < win_op.size()) ? win_op[i] : 8'hXX;
    endfunction

    task automatic clear_mon();
        win_len.delete();
        win_edges.delete();
        win_op.delete();
    endtask

    // Issue go at a negedge; on return the acceptance edge has passed (cycle 0 is the go cycle).
    task automatic start(input bit hold);
        @(negedge clk);
        go = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) go = 1'b0;
    endtask

    logic mid_match;
    task automatic wait_done(input int limit, input int p1, input int p2, output int cyc);
        cyc = -1;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (p1 > 0) go = (c == p1 || c == p2);
            if (c == 40) mid_match = match;
            if (done) begin
                cyc = c;
                break;
            end
        end
        if (p1 > 0) go = 1'b0;
    endtask

    task automatic chk_windows(input string tag);
        chk({tag, "_nwin"}, win_len.size(), 2);
        chk({tag, "_len0"}, qget(win_len, 0), 33);
        chk({tag, "_len1"}, qget(win_len, 1), 33);
        chk({tag, "_edge0"}, qget(win_edges, 0), 16);
        chk({tag, "_edge1"}, qget(win_edges, 1), 16);
        chk({tag, "_op0"}, qop(0), 8'h05);
        chk({tag, "_op1"}, qop(1), 8'h35);
    endtask

    int dc;
    int seen;

    initial begin
        rst = 1'b1; go = 1'b0; spi_miso = 1'b0;
        model_sr1 = 8'h28; model_sr2 = 8'h03;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cs_n", spi_cs_n, 1);
        chk("rst_sclk", spi_clk, 0);
        chk("rst_mosi", spi_mosi, 0);
        chk("rst_done", done, 0);
        chk("rst_match", match, 0);
        chk("rst_sr1", sr1, 8'h00);
        chk("rst_sr2", sr2, 8'h00);
        chk("rst_rdy", rdy, 1);
        rst = 1'b0;

        // Locked part: both compares pass.
        clear_mon();
        start(0);
        wait_done(200, 0, 0, dc);
        chk("r1_done_cyc", dc, 83);
        chk("r1_match", match, 1);
        chk("r1_sr1", sr1, 8'h28);
        chk("r1_sr2", sr2, 8'h03);
        @(negedge clk);
        chk("r1_done_pulse", done, 0);
        chk("r1_rdy", rdy, 1);
        chk_windows("r1");

        // SR1 mismatch; match must also read 0 mid-check after a previous pass.
        model_sr1 = 8'h00;
        clear_mon();
        start(0);
        wait_done(200, 0, 0, dc);
        chk("r2_mid_match", mid_match, 0);
        chk("r2_done_cyc", dc, 83);
        chk("r2_match", match, 0);
        chk("r2_sr1", sr1, 8'h00);
        chk("r2_sr2", sr2, 8'h03);

        // Masked compare: only bits 5..2 of SR1 matter on dut_m.
        model_sr1 = 8'hE9;
        start(0);
        wait_done(200, 0, 0, dc);
        chk("r3_done_cyc", dc, 83);
        chk("r3_match_full", match, 0);
        chk("r3_m_done", m_done, 1);
        chk("r3_m_match", m_match, 1);
        chk("r3_m_sr1", m_sr1, 8'hE9);

        // Reset at cycle 50 aborts the check.
        model_sr1 = 8'h28;
        start(0);
        for (int c = 1; c < 50; c++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("r4_cs_n", spi_cs_n, 1);
        chk("r4_rdy", rdy, 1);
        chk("r4_sr1", sr1, 8'h00);
        chk("r4_sr2", sr2, 8'h00);
        seen = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("r4_no_done", seen, 0);

        // Reset wins over go in the same cycle.
        @(negedge clk);
        rst = 1'b1; go = 1'b1;
        @(negedge clk);
        rst = 1'b0; go = 1'b0;
        @(negedge clk);
        chk("r5_rdy", rdy, 1);
        chk("r5_cs_n", spi_cs_n, 1);

        // go pulses while busy are ignored.
        clear_mon();
        start(0);
        wait_done(200, 20, 60, dc);
        chk("r6_done_cyc", dc, 83);
        chk("r6_match", match, 1);
        chk_windows("r6");

        // go held: back-to-back checks with one IDLE cycle between.
        start(1);
        wait_done(200, 0, 0, dc);
        chk("r7_done_cyc0", dc, 83);
        @(negedge clk);
        chk("r7_idle_gap", rdy, 1);
        wait_done(200, 0, 0, dc);
        go = 1'b0;
        chk("r7_done_cyc1", dc, 83);
        chk("r7_match", match, 1);
        @(negedge clk);
        @(negedge clk);
        chk("r7_stay_idle", rdy, 1);

        chk("protocol", proto_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/flash_sr_check.md
FLASH_SR_CHECK -- requirements
Module: flash_sr_check

Interface
REQ-001 SHALL have parameter CMD_SR1, default 8'h05, meaning opcode for reading SR1.
REQ-002 SHALL have parameter CMD_SR2, default 8'h35, meaning opcode for reading SR2.
REQ-003 SHALL have parameters EXP_SR1 and EXP_SR2, defaults 8'h28 and 8'h03, meaning the expected locked status values.
REQ-004 SHALL have parameters MASK_SR1 and MASK_SR2, defaults 8'hFF and 8'hFF, meaning the bits that take part in the compare (1 = compared).
REQ-005 SHALL have parameter PAUSE_LEN, default 8, meaning the number of CS-high cycles after each transaction (range 2..15).
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port spi_mosi, output, 1 bit, registered.
REQ-009 SHALL have port spi_miso, input, 1 bit.
REQ-010 SHALL have port spi_clk, output, 1 bit, registered; SPI mode 0.
REQ-011 SHALL have port spi_cs_n, output, 1 bit, registered.
REQ-012 SHALL have port go, input, 1 bit: start a check, sampled only in IDLE.
REQ-013 SHALL have port rdy, output, 1 bit: high when state is IDLE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse when the results are valid.
REQ-015 SHALL have port match, output, 1 bit: 1 when both masked compares pass.
REQ-016 SHALL have ports sr1 and sr2, output, 8 bits each: the captured status bytes.

Function
REQ-017 SHALL implement states IDLE, START, CMD_LO, CMD_HI, RD_LO, RD_HI, PAUSE and DONE, plus a 1-bit register index reg_sel.
REQ-018 Transitions SHALL be as follows.
- IDLE goes to START on go; go is ignored in every other state.
- START goes to CMD_LO.
- CMD_LO goes to CMD_HI.
- CMD_HI goes to CMD_LO while bits remain, otherwise to RD_LO.
- RD_LO goes to RD_HI.
- RD_HI goes to RD_LO while bits remain, otherwise to PAUSE.
- PAUSE lasts PAUSE_LEN cycles, then goes to START with reg_sel=1 if reg_sel was 0, otherwise to DONE.
- DONE goes to IDLE.
REQ-019 The 8 opcode bits SHALL be sent MSB first from CMD_SR1 or CMD_SR2 according to reg_sel; 8 read bits SHALL follow.
REQ-020 Output registers SHALL take values from the current state.
- START: cs_n=0, clk=0, mosi=0.
- CMD_LO: cs_n=0, clk=0, mosi=current bit.
- CMD_HI: cs_n=0, clk=1, mosi=current bit.
- RD_LO and RD_HI: cs_n=0, mosi=0, clk=0 in RD_LO and 1 in RD_HI.
- All other states: cs_n=1, clk=0, mosi=0.
REQ-021 A registered flag sample_en SHALL equal (state==RD_HI) delayed by one cycle; when it is high, spi_miso SHALL shift MSB-first into the byte selected by reg_sel, so sampling occurs while spi_clk is high.
REQ-022 The final SR2 sample occurs in the first PAUSE cycle and SHALL be captured before DONE.
REQ-023 sr1 and sr2 SHALL be cleared to 0 on the go acceptance and SHALL hold their captured values from DONE until the next accepted go.
REQ-024 match SHALL be registered on entry to DONE as (((sr1^EXP_SR1)&MASK_SR1)==0) AND (((sr2^EXP_SR2)&MASK_SR2)==0), and held until the next go; match SHALL be 0 while a check is in progress.
REQ-025 done SHALL be high exactly during DONE, i.e. cycle 83 after the go cycle at PAUSE_LEN=8; rdy SHALL go high the following cycle.
REQ-026 The total check length SHALL be 2*(1+32+PAUSE_LEN)+1 cycles from START to DONE inclusive.
REQ-027 A go held high continuously SHALL restart a check the cycle after IDLE is re-entered.

Reset
REQ-028 rst SHALL force the following on the next clock edge: state=IDLE, reg_sel=0, spi_cs_n=1, spi_clk=0, spi_mosi=0, done=0, match=0, sr1=0, sr2=0, sample_en=0.
REQ-029 rst asserted mid-transaction SHALL abort it with CS released on the next edge and no done pulse.
REQ-030 rst SHALL take priority over go in the same cycle.

Structure
REQ-031 Default opcodes and expected SR values SHALL live in a shared flash-constants package also used by the lock sequencer, so the locked values are defined once.
REQ-032 The bit counter SHALL be 4 bits and reload at 6, with the last bit flagged by counter[3]; the pause counter SHALL be a separate 4-bit counter.
REQ-033 The block SHALL be a single module with no sub-module; SPI pin multiplexing with other masters is external.

Verification
REQ-034 Flash model returns SR1=8'h28 and SR2=8'h03; pulse go -> MOSI carries 8'h05 then 8'h35, two CS-low windows of 33 cycles, done at cycle 83, match=1, sr1=8'h28, sr2=8'h03.
REQ-035 Model returns SR1=8'h00 -> done with match=0, sr1=8'h00.
REQ-036 MASK_SR1=8'h3C and model SR1=8'hE9 -> match=1, since the masked bits equal those of 8'h28.
REQ-037 rst asserted at cycle 50 -> spi_cs_n=1 and rdy=1 by cycle 52, done never asserted, sr1=sr2=0.
REQ-038 go pulsed mid-transaction -> ignored, with timing identical to REQ-034; go held high -> back-to-back checks with exactly one IDLE cycle between them.
REQ-039 Protocol checker on every run -> spi_clk never high while spi_cs_n=1, MOSI stable across each spi_clk high phase, and exactly 16 rising edges per CS window.
